bsg_wormhole_dma_initiator: RTL

- Wormhole-side initiator for vcache-style DMA traffic.
- Accepts block read/write commands from a local client and serialises them into wormhole packets: one header flit, plus data flits on writes.
- Collects the single matching response packet from the memory responder.
- Serves as the gateway-side traffic source and bring-up exerciser for wormhole memory links; allows exactly one outstanding transaction.

---
 rtl/bsg_wormhole_dma_pkg.sv | 37 +++
 rtl/bsg_wormhole_dma_flit_sipo.sv | 41 ++++
 rtl/bsg_wormhole_dma_initiator.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_wormhole_dma_pkg.sv
// Shared definitions for the wormhole DMA initiator: header layout macro, opcode bits,
// FSM state encoding and block geometry helpers.

`define BSG_WORMHOLE_DMA_HDR_S(addr_w, cid_w, cord_w, len_w) \
    typedef struct packed {                                   \
        logic [addr_w-1:0] addr;                              \
        logic              write;                             \
        logic [cid_w-1:0]  cid;                               \
        logic [cord_w-1:0] src_cord;                          \
        logic [len_w-1:0]  len;                               \
        logic [cord_w-1:0] dest_cord;                         \
    } dma_hdr_s;

package bsg_wormhole_dma_pkg;

    localparam logic dma_op_read_c  = 1'b0;
    localparam logic dma_op_write_c = 1'b1;

    typedef enum logic [2:0] {
        e_idle,
        e_send_hdr,
        e_send_data,
        e_wait_hdr,
        e_recv_data,
        e_resp
    } dma_state_e;

    function automatic int dma_data_flits(input int words, input int data_w, input int flit_w);
        return (words * data_w) / flit_w;
    endfunction

    function automatic int dma_hdr_width(input int addr_w, input int cid_w,
                                         input int cord_w, input int len_w);
        return 2 * cord_w + len_w + cid_w + 1 + addr_w;
    endfunction

endpackage

// File: rtl/bsg_wormhole_dma_flit_sipo.sv
// Block-wide serial-in register: each fill writes the next flit slot, LSB slot first.

module bsg_wormhole_dma_flit_sipo #(
    parameter int flit_width_p = 64,
    parameter int data_flits_p = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 clear_i,
    input  logic                                 fill_i,
    input  logic                                 zero_i,
    input  logic [flit_width_p-1:0]              data_i,
    output logic [data_flits_p*flit_width_p-1:0] data_o
);

    localparam int slot_width_lp = (data_flits_p > 1) ? $clog2(data_flits_p) : 1;

    logic [slot_width_lp-1:0]                   slot_r;
    logic [data_flits_p-1:0][flit_width_p-1:0]  data_r;

    // NOTE: the block register is reset too, so a response that never filled it reads as zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_r <= '0;
            data_r <= '0;
        end else begin
            if (clear_i) begin
                slot_r <= '0;
            end else if (fill_i) begin
                data_r[slot_r] <= data_i;
                slot_r         <= slot_r + 1'b1;
            end
            if (zero_i) begin
                data_r <= '0;
            end
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_wormhole_dma_initiator.sv
// Wormhole DMA initiator: one outstanding block read/write, header + data flits out, one response in.
// Optional response watchdog: define BSG_WORMHOLE_DMA_INITIATOR_TIMEOUT_EN.

module bsg_wormhole_dma_initiator
    import bsg_wormhole_dma_pkg::*;
#(
    parameter int flit_width_p          = 64,
    parameter int cord_width_p          = 7,
    parameter int len_width_p           = 4,
    parameter int cid_width_p           = 5,
    parameter int addr_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int data_width_p          = 32,
    parameter int timeout_p             = 1024
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [cord_width_p-1:0]                       my_cord_i,
    input  logic [cid_width_p-1:0]                        my_cid_i,
    input  logic                                          cmd_v_i,
    output logic                                          cmd_ready_o,
    input  logic                                          cmd_write_i,
    input  logic [cord_width_p-1:0]                       cmd_dest_cord_i,
    input  logic [addr_width_p-1:0]                       cmd_addr_i,
    input  logic [block_size_in_words_p*data_width_p-1:0] cmd_data_i,
    output logic                                          resp_v_o,
    input  logic                                          resp_yumi_i,
    output logic                                          resp_write_o,
    output logic [block_size_in_words_p*data_width_p-1:0] resp_data_o,
    output logic [flit_width_p-1:0]                       link_data_o,
    output logic                                          link_v_o,
    input  logic                                          link_ready_i,
    input  logic [flit_width_p-1:0]                       link_data_i,
    input  logic                                          link_v_i,
    output logic                                          link_ready_o,
    output logic                                          error_o
);

    localparam int block_width_lp = block_size_in_words_p * data_width_p;
    localparam int data_flits_lp  = dma_data_flits(block_size_in_words_p, data_width_p, flit_width_p);
    localparam int hdr_width_lp   = dma_hdr_width(addr_width_p, cid_width_p, cord_width_p, len_width_p);
    localparam int cnt_width_lp   = (data_flits_lp > 1) ? $clog2(data_flits_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_slot_lp = cnt_width_lp'(data_flits_lp - 1);
    localparam logic [len_width_p-1:0]  data_len_lp  = len_width_p'(data_flits_lp);

    if ((block_width_lp % flit_width_p) != 0) begin : g_bad_div
        $error("block width must be a multiple of flit_width_p");
    end
    if (data_flits_lp >= (1 << len_width_p)) begin : g_bad_len
        $error("data flit count does not fit in the len field");
    end
    if (hdr_width_lp > flit_width_p) begin : g_bad_hdr
        $error("header does not fit in one flit");
    end
    if (timeout_p < 1) begin : g_bad_timeout
        $error("timeout_p must be positive");
    end

    `BSG_WORMHOLE_DMA_HDR_S(addr_width_p, cid_width_p, cord_width_p, len_width_p)

    dma_state_e                                state_r;
    logic                                      write_r;
    logic [cord_width_p-1:0]                   dest_r;
    logic [addr_width_p-1:0]                   addr_r;
    logic [data_flits_lp-1:0][flit_width_p-1:0] data_r;
    logic [cnt_width_lp-1:0]                   tx_cnt_r;
    logic [len_width_p-1:0]                    rx_left_r;
    logic                                      drain_r;
    logic                                      resp_write_r;
    logic                                      cmd_ready_r;
    logic                                      link_v_r;
    logic                                      link_ready_r;
    logic                                      resp_v_r;
    logic                                      error_r;

    dma_hdr_s                                  tx_hdr;
    dma_hdr_s                                  rx_hdr;
    logic [len_width_p-1:0]                    exp_resp_len;
    logic                                      rx_mismatch;
    logic                                      hdr_accept;
    logic                                      fill;
    logic                                      timeout_hit;
    logic                                      unused_rx_fields;

    always_comb begin
        tx_hdr           = '0;
        tx_hdr.dest_cord = dest_r;
        tx_hdr.len       = (write_r == dma_op_write_c) ? data_len_lp : '0;
        tx_hdr.src_cord  = my_cord_i;
        tx_hdr.cid       = my_cid_i;
        tx_hdr.write     = write_r;
        tx_hdr.addr      = addr_r;
    end

    assign rx_hdr       = dma_hdr_s'(link_data_i[hdr_width_lp-1:0]);
    assign exp_resp_len = (write_r == dma_op_read_c) ? data_len_lp : '0;
    assign rx_mismatch  = (rx_hdr.write != write_r) || (rx_hdr.len != exp_resp_len);
    assign hdr_accept   = (state_r == e_wait_hdr) && link_v_i && link_ready_r && !timeout_hit;
    assign fill         = (state_r == e_recv_data) && link_v_i && link_ready_r && !drain_r && !timeout_hit;

    // Routing fields of the response header are not needed once it has reached us.
    assign unused_rx_fields = ^{rx_hdr.dest_cord, rx_hdr.src_cord, rx_hdr.cid, rx_hdr.addr};

`ifdef BSG_WORMHOLE_DMA_INITIATOR_TIMEOUT_EN
    localparam int to_width_lp = $clog2(timeout_p + 1);

    logic [to_width_lp-1:0] to_cnt_r;
    logic                   waiting;

    assign waiting     = (state_r == e_wait_hdr) || (state_r == e_recv_data);
    assign timeout_hit = waiting && (to_cnt_r == to_width_lp'(timeout_p));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_cnt_r <= '0;
        end else if (!waiting) begin
            to_cnt_r <= '0;
        end else if (!timeout_hit) begin
            to_cnt_r <= to_cnt_r + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: every output valid/ready is a register updated alongside the state, using <= only.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= e_idle;
            write_r      <= 1'b0;
            dest_r       <= '0;
            addr_r       <= '0;
            data_r       <= '0;
            tx_cnt_r     <= '0;
            rx_left_r    <= '0;
            drain_r      <= 1'b0;
            resp_write_r <= 1'b0;
            cmd_ready_r  <= 1'b0;
            link_v_r     <= 1'b0;
            link_ready_r <= 1'b0;
            resp_v_r     <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            case (state_r)
                e_idle: begin
                    cmd_ready_r <= 1'b1;
                    if (cmd_v_i && cmd_ready_r) begin
                        write_r     <= cmd_write_i;
                        dest_r      <= cmd_dest_cord_i;
                        addr_r      <= cmd_addr_i;
                        data_r      <= cmd_data_i;
                        cmd_ready_r <= 1'b0;
                        link_v_r    <= 1'b1;
                        state_r     <= e_send_hdr;
                    end
                end
                e_send_hdr: begin
                    if (link_ready_i) begin
                        tx_cnt_r <= '0;
                        if (write_r == dma_op_write_c) begin
                            state_r <= e_send_data;
                        end else begin
                            link_v_r     <= 1'b0;
                            link_ready_r <= 1'b1;
                            state_r      <= e_wait_hdr;
                        end
                    end
                end
                e_send_data: begin
                    if (link_ready_i) begin
                        if (tx_cnt_r == last_slot_lp) begin
                            link_v_r     <= 1'b0;
                            link_ready_r <= 1'b1;
                            state_r      <= e_wait_hdr;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + 1'b1;
                        end
                    end
                end
                e_wait_hdr: begin
                    if (timeout_hit) begin
                        error_r      <= 1'b1;
                        resp_write_r <= write_r;
                        link_ready_r <= 1'b0;
                        resp_v_r     <= 1'b1;
                        state_r      <= e_resp;
                    end else if (link_v_i) begin
                        resp_write_r <= rx_hdr.write;
                        rx_left_r    <= rx_hdr.len;
                        drain_r      <= rx_mismatch;
                        if (rx_mismatch) begin
                            error_r <= 1'b1;
                        end
                        if (rx_hdr.len == '0) begin
                            link_ready_r <= 1'b0;
                            resp_v_r     <= 1'b1;
                            state_r      <= e_resp;
                        end else begin
                            state_r <= e_recv_data;
                        end
                    end
                end
                e_recv_data: begin
                    if (timeout_hit) begin
                        error_r      <= 1'b1;
                        link_ready_r <= 1'b0;
                        resp_v_r     <= 1'b1;
                        state_r      <= e_resp;
                    end else if (link_v_i) begin
                        if (rx_left_r == len_width_p'(1)) begin
                            link_ready_r <= 1'b0;
                            resp_v_r     <= 1'b1;
                            state_r      <= e_resp;
                        end else begin
                            rx_left_r <= rx_left_r - 1'b1;
                        end
                    end
                end
                e_resp: begin
                    if (resp_yumi_i) begin
                        resp_v_r    <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= e_idle;
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    bsg_wormhole_dma_flit_sipo #(
        .flit_width_p(flit_width_p),
        .data_flits_p(data_flits_lp)
    ) u_sipo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (hdr_accept),
        .fill_i   (fill),
        .zero_i   (timeout_hit),
        .data_i   (link_data_i),
        .data_o   (resp_data_o)
    );

    assign link_data_o  = (state_r == e_send_data) ? data_r[tx_cnt_r] : flit_width_p'(tx_hdr);
    assign cmd_ready_o  = cmd_ready_r;
    assign link_v_o     = link_v_r;
    assign link_ready_o = link_ready_r;
    assign resp_v_o     = resp_v_r;
    assign resp_write_o = resp_write_r;
    assign error_o      = error_r;

endmodule
